adder_bist_checker: RTL and testbench

- Synthesizable self-checking stimulus and response block for the 16-bit mixed adder (mix16bitaddr family).
- Drives {A,B,Cin} vectors into the adder and consumes its Sum/Cout.
- Compares each result against a golden sum, counts mismatches and captures the first failing vector.
- Replaces simulation-only $monitor checking; used for on-FPGA BIST of adder variants with 0..N pipeline stages.

---
 rtl/adder_bist_pkg.sv | 16 +
 rtl/bist_lfsr33.sv | 19 +
 rtl/adder_bist_checker.sv | 130 +++++++++++++
 tb/tb_adder_bist_checker.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg: shared constants, state encoding and LFSR helpers for the adder BIST checker.
package adder_bist_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_LAT   = 0;
    localparam int LFSR_W    = 33;
    localparam int TAP_HI    = 32;
    localparam int TAP_LO    = 19;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 33'd1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Fibonacci x^33+x^20+1: shift toward the MSB, feedback enters at bit 0
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction
endpackage

// File: rtl/bist_lfsr33.sv
// bist_lfsr33: 33-bit maximal-length LFSR with seed load and step enable.
module bist_lfsr33
    import adder_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= LFSR_SEED;
        else if (load)
            state <= LFSR_SEED;
        else if (en)
            state <= lfsr_step(state);
    end
endmodule

// File: rtl/adder_bist_checker.sv
// adder_bist_checker: drives {A,B,Cin} vectors into an adder, checks {Cout,Sum} against a golden sum
// delayed by the adder latency, counts mismatches and captures the first failing vector.
module adder_bist_checker
    import adder_bist_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = DEF_LAT,
    parameter int ERR_W = 16,
    parameter int CNT_W = 2 * WIDTH + 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Mode,
    input  logic [CNT_W-1:0] NumVec,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Cin,
    input  logic [WIDTH-1:0] Sum,
    input  logic             Cout,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic [ERR_W-1:0] ErrCount,
    output logic [CNT_W-1:0] FailVec,
    output logic [WIDTH:0]   FailRes
);
    localparam int DW = $clog2(LAT + 2);
    localparam logic [DW-1:0] LAT_C = DW'(LAT);

    state_t state, state_nx;
    logic mode_q, empty, zero, start_ok, first, issue, push;
    logic [CNT_W-1:0] num_q, idx, vec, vec_nx;
    logic [DW-1:0] dcnt;
    logic [LFSR_W-1:0] lfsr_q;
    logic [WIDTH:0] gold;
    logic [LAT:0] pv;
    logic [WIDTH:0] pexp [LAT+1];
    logic [CNT_W-1:0] pvec [LAT+1];

    bist_lfsr33 u_lfsr (
        .clk  (Clk),
        .rst_n(Rst_n),
        .load (first),
        .en   (issue && mode_q),
        .state(lfsr_q)
    );

    // empty marks the one idle cycle of a zero-length run; Start is not accepted then
    assign zero     = NumVec == '0;
    assign start_ok = Start && !empty && (state == IDLE || state == DONE);
    assign first    = start_ok && !zero;
    assign issue    = state == RUN && idx != num_q;
    assign push     = first || issue;
    assign vec_nx   = first ? (Mode ? CNT_W'(LFSR_SEED) : '0)
                    : mode_q ? CNT_W'(lfsr_step(lfsr_q)) : idx;
    assign gold     = {1'b0, vec_nx[CNT_W-1 -: WIDTH]} + {1'b0, vec_nx[1 +: WIDTH]}
                    + {{WIDTH{1'b0}}, vec_nx[0]};

    assign A    = vec[CNT_W-1 -: WIDTH];
    assign B    = vec[1 +: WIDTH];
    assign Cin  = vec[0];
    assign Busy = state == RUN || state == DRAIN;
    assign Done = state == DONE;
    assign Pass = Done && ErrCount == '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = empty ? DONE : start_ok ? (zero ? IDLE : RUN) : IDLE;
            RUN:     state_nx = idx == num_q ? DRAIN : RUN;
            DRAIN:   state_nx = dcnt == LAT_C ? DONE : DRAIN;
            DONE:    state_nx = start_ok ? (zero ? IDLE : RUN) : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            empty    <= 1'b0;
            num_q    <= '0;
            idx      <= '0;
            vec      <= '0;
            dcnt     <= '0;
            pv       <= '0;
            ErrCount <= '0;
            FailVec  <= '0;
            FailRes  <= '0;
            for (int i = 0; i <= LAT; i++) begin
                pexp[i] <= '0;
                pvec[i] <= '0;
            end
        end else begin
            state <= state_nx;
            empty <= start_ok && zero;
            dcnt  <= state == DRAIN ? dcnt + 1'b1 : '0;
            pv[0]   <= push;
            pexp[0] <= gold;
            pvec[0] <= vec_nx;
            for (int i = 1; i <= LAT; i++) begin
                pv[i]   <= pv[i-1];
                pexp[i] <= pexp[i-1];
                pvec[i] <= pvec[i-1];
            end
            if (push)
                vec <= vec_nx;
            if (issue)
                idx <= idx + 1'b1;
            if (pv[LAT] && {Cout, Sum} != pexp[LAT]) begin
                if (ErrCount == '0) begin
                    FailVec <= pvec[LAT];
                    FailRes <= {Cout, Sum};
                end
                if (ErrCount != '1)
                    ErrCount <= ErrCount + 1'b1;
            end
            // the pipeline is always empty when a run can start, so this clear never races a compare
            if (start_ok) begin
                mode_q   <= Mode;
                num_q    <= NumVec;
                idx      <= CNT_W'(1);
                ErrCount <= '0;
                FailVec  <= '0;
                FailRes  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_adder_bist_checker.sv
// tb_adder_bist_checker: three checker instances (combinational adder with optional Sum[0] fault,
// 2-stage registered adder, Cout stuck-at-1 with a 4-bit error counter) against a run-level model.
module tb_adder_bist_checker;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Rst_n = 1'b1, Start = 1'b0, Mode = 1'b0, sum0_stuck = 1'b0;
    logic [32:0] NumVec = '0;

    logic [15:0] a_o [3], b_o [3];
    logic        cin_o [3], busy_o [3], done_o [3], pass_o [3];
    logic [15:0] err_o [2];
    logic [3:0]  err4;
    logic [32:0] fv_o [3];
    logic [16:0] fr_o [3];
    logic [15:0] s0, s1, s2;
    logic        c0, c1, c2;
    logic [16:0] r0, r2, q1, q2;

    assign r0 = {1'b0, a_o[0]} + {1'b0, b_o[0]} + {16'd0, cin_o[0]};
    assign s0 = {r0[15:1], r0[0] & ~sum0_stuck};
    assign c0 = r0[16];
    always @(posedge Clk) begin
        q1 <= {1'b0, a_o[1]} + {1'b0, b_o[1]} + {16'd0, cin_o[1]};
        q2 <= q1;
    end
    assign {c1, s1} = q2;
    assign r2 = {1'b0, a_o[2]} + {1'b0, b_o[2]} + {16'd0, cin_o[2]};
    assign s2 = r2[15:0];
    assign c2 = 1'b1;

    adder_bist_checker #(.LAT(0)) u0 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Mode(Mode), .NumVec(NumVec),
        .A(a_o[0]), .B(b_o[0]), .Cin(cin_o[0]), .Sum(s0), .Cout(c0),
        .Busy(busy_o[0]), .Done(done_o[0]), .Pass(pass_o[0]), .ErrCount(err_o[0]),
        .FailVec(fv_o[0]), .FailRes(fr_o[0]));

    adder_bist_checker #(.LAT(2)) u2 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Mode(Mode), .NumVec(NumVec),
        .A(a_o[1]), .B(b_o[1]), .Cin(cin_o[1]), .Sum(s1), .Cout(c1),
        .Busy(busy_o[1]), .Done(done_o[1]), .Pass(pass_o[1]), .ErrCount(err_o[1]),
        .FailVec(fv_o[1]), .FailRes(fr_o[1]));

    adder_bist_checker #(.ERR_W(4)) u4 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Mode(Mode), .NumVec(NumVec),
        .A(a_o[2]), .B(b_o[2]), .Cin(cin_o[2]), .Sum(s2), .Cout(c2),
        .Busy(busy_o[2]), .Done(done_o[2]), .Pass(pass_o[2]), .ErrCount(err4),
        .FailVec(fv_o[2]), .FailRes(fr_o[2]));

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit act [3], md [3], flt [3];
    int e0 [3], nn [3];
    logic [32:0] held [3];
    logic [32:0] seq [128];
    int b0, b2;
    logic [32:0] v3 [3];

    task automatic chk(input string name, input int inst, input longint act_v, input longint exp_v);
        n_chk++;
        if (act_v != exp_v) begin
            n_fail++;
            $display("FAIL %s[inst %0d] at %0t: got 0x%0h, expected 0x%0h", name, inst, $time, act_v, exp_v);
        end
    endtask

    // LFSR sequence as a bit stream: b[t] = b[t-33] ^ b[t-20]; the state holds the last 33 bits
    task automatic build_seq();
        bit hist [200];
        foreach (hist[j]) hist[j] = 1'b0;
        hist[32] = 1'b1;
        for (int t = 0; t + 33 < 200; t++) hist[t+33] = hist[t] ^ hist[t+13];
        for (int t = 0; t < 128; t++)
            for (int i = 0; i < 33; i++) seq[t][i] = hist[t+32-i];
    endtask

    function automatic int lat_of(input int i);
        return i == 1 ? 2 : 0;
    endfunction

    function automatic int emax(input int i);
        return i == 2 ? 15 : 65535;
    endfunction

    function automatic logic [32:0] vec_of(input bit m, input int k);
        return m ? seq[k & 127] : 33'(k);
    endfunction

    function automatic logic [16:0] golden(input logic [32:0] v);
        return {1'b0, v[32:17]} + {1'b0, v[16:1]} + {16'd0, v[0]};
    endfunction

    function automatic logic [16:0] dut_res(input int i, input bit f, input logic [32:0] v);
        logic [16:0] r;
        r = golden(v);
        if (i == 0 && f) r[0] = 1'b0;
        if (i == 2) r[16] = 1'b1;
        return r;
    endfunction

    function automatic longint err_of(input int i);
        return i == 2 ? longint'(err4) : longint'(err_o[i]);
    endfunction

    task automatic model_step();
        int c;
        bit idle;
        if (!Rst_n) begin
            for (int i = 0; i < 3; i++) begin
                act[i] = 1'b0;
                held[i] = '0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 3; i++) begin
                c = cyc - e0[i];
                idle = !act[i] || (nn[i] == 0 ? c >= 2 : c >= nn[i] + lat_of(i) + 2);
                if (Start && idle) begin
                    if (act[i] && nn[i] != 0) held[i] = vec_of(md[i], nn[i] - 1);
                    act[i] = 1'b1;
                    e0[i]  = cyc;
                    nn[i]  = int'(NumVec);
                    md[i]  = Mode;
                    flt[i] = (i == 0) && sum0_stuck;
                end
            end
        end
    endtask

    task automatic compare_all();
        int c, n, l, err;
        bit eb, ed;
        logic [32:0] v, ev, efv;
        logic [16:0] r, efr;
        for (int i = 0; i < 3; i++) begin
            l = lat_of(i); n = nn[i]; c = cyc - e0[i];
            eb = 1'b0; ed = 1'b0; ev = held[i]; err = 0; efv = '0; efr = '0;
            if (act[i]) begin
                if (n == 0) ed = c >= 1;
                else begin
                    eb = c <= n + l;
                    ed = c >= n + l + 1;
                    ev = vec_of(md[i], c < n ? c : n - 1);
                    for (int k = 0; k < n && k + l + 1 <= c; k++) begin
                        v = vec_of(md[i], k);
                        r = dut_res(i, flt[i], v);
                        if (r != golden(v)) begin
                            if (err == 0) begin efv = v; efr = r; end
                            if (err < emax(i)) err++;
                        end
                    end
                end
            end
            chk("vector", i, {a_o[i], b_o[i], cin_o[i]}, ev);
            chk("busy", i, busy_o[i], eb);
            chk("done", i, done_o[i], ed);
            chk("pass", i, pass_o[i], ed && err == 0);
            chk("errcount", i, err_of(i), err);
            chk("failvec", i, fv_o[i], efv);
            chk("failres", i, fr_o[i], efr);
        end
    endtask

    initial forever begin
        @(posedge Clk or negedge Rst_n);
        model_step();
    end

    initial forever begin
        @(negedge Clk);
        compare_all();
    end

    task automatic run(input int n, input bit m);
        @(negedge Clk);
        Mode = m; NumVec = 33'(n); Start = 1'b1;
        b0 = 0; b2 = 0;
        for (int t = 0; t < n + 10; t++) begin
            @(negedge Clk);
            Start = 1'b0;
            b0 += int'(busy_o[0]);
            b2 += int'(busy_o[1]);
            if (t < 3) v3[t] = {a_o[1], b_o[1], cin_o[1]};
        end
    endtask

    initial begin
        build_seq();
        #1 Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_a", 0, a_o[0], 0);
        chk("rst_done", 0, done_o[0], 0);
        Rst_n = 1'b1;

        run(16, 1'b0);
        chk("lit_busy16", 0, b0, 17);
        chk("lit_pass16", 0, pass_o[0], 1);
        chk("lit_err16", 0, err_o[0], 0);
        chk("lit_busy16_lat2", 1, b2, 19);

        sum0_stuck = 1'b1;
        run(4, 1'b0);
        chk("lit_err_s0", 0, err_o[0], 2);
        chk("lit_fv_s0", 0, fv_o[0], 1);
        chk("lit_fr_s0", 0, fr_o[0], 0);
        chk("lit_pass_s0", 0, pass_o[0], 0);
        sum0_stuck = 1'b0;

        run(100, 1'b1);
        chk("lit_busy100", 1, b2, 103);
        chk("lit_pass100", 1, pass_o[1], 1);
        chk("lit_lfsr0", 1, v3[0], 33'h000000001);
        chk("lit_lfsr1", 1, v3[1], 33'h000000002);
        chk("lit_lfsr2", 1, v3[2], 33'h000000004);

        run(32, 1'b0);
        chk("lit_err_sat", 2, err4, 15);
        chk("lit_fv_sat", 2, fv_o[2], 0);
        chk("lit_fr_sat", 2, fr_o[2], 17'h10000);

        @(negedge Clk);
        NumVec = '0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("lit_zero_done0", 0, done_o[0], 0);
        chk("lit_zero_busy0", 0, busy_o[0], 0);
        @(negedge Clk);
        chk("lit_zero_done1", 0, done_o[0], 1);
        chk("lit_zero_pass", 0, pass_o[0], 1);
        chk("lit_zero_busy1", 0, busy_o[0], 0);
        chk("lit_zero_vec", 0, {a_o[0], b_o[0], cin_o[0]}, 33'd31);
        repeat (3) @(negedge Clk);

        Mode = 1'b0; NumVec = 33'd20; Start = 1'b1;
        b0 = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge Clk);
            Start = (t == 5);
            if (t == 5) begin Mode = 1'b1; NumVec = 33'd3; end
            b0 += int'(busy_o[0]);
        end
        Start = 1'b0;
        chk("lit_ign_busy", 0, b0, 21);
        chk("lit_ign_pass", 0, pass_o[0], 1);
        chk("lit_ign_b", 0, b_o[0], 9);
        chk("lit_ign_cin", 0, cin_o[0], 1);

        @(negedge Clk);
        Mode = 1'b0; NumVec = 33'd20; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("lit_abort_busy", 0, busy_o[0], 0);
        chk("lit_abort_vec", 0, {a_o[0], b_o[0], cin_o[0]}, 0);
        chk("lit_abort_err", 0, err_o[0], 0);
        chk("lit_abort_done", 0, done_o[0], 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        run(8, 1'b0);
        chk("lit_rerun_pass", 0, pass_o[0], 1);
        chk("lit_rerun_busy", 0, b0, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
